// File: rtl/sp_sram.sv
// ---------------------------------------------------------------------------
// sp_sram
//   Parameterised single-port synchronous SRAM. One shared address serves
//   both reads and writes on a single clock. Optional address-input register,
//   optional output register and optional even-parity output.
//
// Ports
//   clk         in   1          rising-edge clock
//   rst         in   1          asynchronous, active-high reset (registers only)
//   din         in   MEM_WIDTH  write data
//   addr        in   ADDR_SIZE  word address (read and write)
//   wr_en       in   1          write enable
//   rd_en       in   1          read enable
//   blk_select  in   1          block enable; gates every access and register load
//   addr_en     in   1          address register load enable (ADDR_PIPELINE="TRUE")
//   dout_en     in   1          output register load enable (DOUT_PIPELINE="TRUE")
//   dout        out  MEM_WIDTH  read data
//   parity_out  out  1          even parity of dout (0 when PARITY_ENABLE=0)
// ---------------------------------------------------------------------------
module sp_sram #(
    parameter int    MEM_WIDTH     = 16,
    parameter int    MEM_DEPTH     = 1024,
    parameter int    ADDR_SIZE     = 10,
    parameter string ADDR_PIPELINE = "FALSE",
    parameter string DOUT_PIPELINE = "TRUE",
    parameter int    PARITY_ENABLE = 1
) (
    input  logic [MEM_WIDTH-1:0] din,
    input  logic [ADDR_SIZE-1:0] addr,
    input  logic                 wr_en,
    input  logic                 rd_en,
    input  logic                 blk_select,
    input  logic                 addr_en,
    input  logic                 dout_en,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 parity_out,
    input  logic                 clk,
    input  logic                 rst
);

    // One extra bit so a depth of exactly 2**ADDR_SIZE is representable.
    localparam logic [ADDR_SIZE:0] DEPTH_L = (ADDR_SIZE + 1)'(MEM_DEPTH);

    logic [MEM_WIDTH-1:0] RAM [0:MEM_DEPTH-1];

    logic [ADDR_SIZE-1:0] ea;
    logic                 in_range;
    logic [MEM_WIDTH-1:0] rd_reg;

    // ------------------------------------------------------------------
    // Effective address: registered or straight from the port.
    // ------------------------------------------------------------------
    generate
        if (ADDR_PIPELINE == "TRUE") begin : g_addr_reg
            logic [ADDR_SIZE-1:0] addr_reg;

            // NOTE: state registers use non-blocking assignments so every
            // flop samples pre-edge values regardless of block ordering.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    addr_reg <= '0;
                end else if (blk_select && addr_en) begin
                    addr_reg <= addr;
                end
            end

            assign ea = addr_reg;
        end else begin : g_addr_direct
            logic unused_addr_en;
            assign unused_addr_en = addr_en;
            assign ea             = addr;
        end
    endgenerate

    // Addresses beyond the populated depth neither write nor return data.
    assign in_range = ({1'b0, ea} < DEPTH_L);

    // ------------------------------------------------------------------
    // Storage array write port.
    // ------------------------------------------------------------------
    // NOTE: the array has no reset branch -- clearing a RAM is not something
    // the macro can do, and the contents must survive rst anyway.
    always_ff @(posedge clk) begin
        if (!rst && blk_select && wr_en && in_range) begin
            RAM[ea] <= din;
        end
    end

    // ------------------------------------------------------------------
    // Array read register. Read-first: a simultaneous write to the same
    // word lands after this samples the old contents.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_reg <= '0;
        end else if (blk_select && rd_en) begin
            rd_reg <= in_range ? RAM[ea] : '0;
        end
    end

    // ------------------------------------------------------------------
    // Output stage.
    // ------------------------------------------------------------------
    generate
        if (DOUT_PIPELINE == "TRUE") begin : g_dout_reg
            logic [MEM_WIDTH-1:0] out_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_reg <= '0;
                end else if (blk_select && dout_en) begin
                    out_reg <= rd_reg;
                end
            end

            assign dout = out_reg;
        end else begin : g_dout_direct
            logic unused_dout_en;
            assign unused_dout_en = dout_en;
            assign dout           = rd_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Even parity over the visible read data.
    // ------------------------------------------------------------------
    generate
        if (PARITY_ENABLE != 0) begin : g_parity
            assign parity_out = ^dout;
        end else begin : g_no_parity
            assign parity_out = 1'b0;
        end
    endgenerate

endmodule

// File: tb/tb_sp_sram.sv
// ---------------------------------------------------------------------------
// tb_sp_sram
//   Self-checking bench for sp_sram at default parameters (address direct,
//   output register on, parity on). Reads push their expected word into a
//   scoreboard queue with the cycle it must appear on dout; the queue is
//   drained at each falling edge.
// ---------------------------------------------------------------------------
module tb_sp_sram;

    localparam int W     = 16;
    localparam int DEPTH = 1024;
    localparam int AW    = 10;

    logic          clk;
    logic          rst;
    logic [W-1:0]  din;
    logic [AW-1:0] addr;
    logic          wr_en;
    logic          rd_en;
    logic          blk_select;
    logic          addr_en;
    logic          dout_en;
    logic [W-1:0]  dout;
    logic          parity_out;

    sp_sram #(
        .MEM_WIDTH     (W),
        .MEM_DEPTH     (DEPTH),
        .ADDR_SIZE     (AW),
        .ADDR_PIPELINE ("FALSE"),
        .DOUT_PIPELINE ("TRUE"),
        .PARITY_ENABLE (1)
    ) dut (
        .din        (din),
        .addr       (addr),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .blk_select (blk_select),
        .addr_en    (addr_en),
        .dout_en    (dout_en),
        .dout       (dout),
        .parity_out (parity_out),
        .clk        (clk),
        .rst        (rst)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [W-1:0] data;
        int           due;
    } exp_t;

    exp_t         sb_q [$];
    logic [W-1:0] model_mem [0:DEPTH-1];
    int           cyc   = 0;
    int           total = 0;
    int           bad   = 0;

    // Compare every scoreboard entry whose due cycle has been reached.
    task automatic drain();
        exp_t e;
        while (sb_q.size() != 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            total++;
            if (dout !== e.data) begin
                bad++;
                $display("FAIL sb_dout cyc=%0d got=%h exp=%h", cyc, dout, e.data);
            end
            total++;
            if (parity_out !== ^e.data) begin
                bad++;
                $display("FAIL sb_parity cyc=%0d got=%b exp=%b", cyc, parity_out, ^e.data);
            end
        end
    endtask

    // One clock of stimulus, applied just after a falling edge.
    task automatic step(input logic wr, input logic rd, input logic blk,
                        input logic [AW-1:0] a, input logic [W-1:0] d);
        exp_t e;
        wr_en      = wr;
        rd_en      = rd;
        blk_select = blk;
        addr       = a;
        din        = d;
        if (blk && rd && dout_en) begin
            e.data = model_mem[a];
            e.due  = cyc + 2;
            sb_q.push_back(e);
        end
        if (blk && wr) model_mem[a] = d;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        drain();
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b1, '0, '0);
    endtask

    // Let outstanding reads retire; a bounded wait that reports a stall.
    task automatic flush();
        for (int i = 0; i < 4 && sb_q.size() != 0; i++) idle();
        if (sb_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL flush_timeout pending=%0d required=0", sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        rd_en      = 1'b1;
        blk_select = 1'b1;
        dout_en    = 1'b1;
        addr       = 10'd3;
        #1;
        total++;
        if (dout !== 16'h0000 || parity_out !== 1'b0) begin
            bad++;
            $display("FAIL reset_immediate got=%h/%b exp=0000/0", dout, parity_out);
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            @(negedge clk);
            total++;
            if (dout !== 16'h0000 || parity_out !== 1'b0) begin
                bad++;
                $display("FAIL reset_held got=%h/%b exp=0000/0", dout, parity_out);
            end
        end
        rd_en = 1'b0;
        rst   = 1'b0;
    endtask

    task automatic test_basic();
        step(1'b1, 1'b0, 1'b1, 10'd3, 16'hA5A5);
        step(1'b0, 1'b1, 1'b1, 10'd3, 16'h0000);
        // One edge after the address is sampled the output register has
        // not been loaded yet.
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL basic_latency got=%h exp=0000", dout);
        end
        flush();
    endtask

    task automatic test_parity();
        step(1'b1, 1'b0, 1'b1, 10'd10, 16'h0001);
        step(1'b0, 1'b1, 1'b1, 10'd10, 16'h0000);
        flush();
    endtask

    task automatic test_blk_select();
        step(1'b1, 1'b0, 1'b0, 10'd3, 16'hFFFF);
        // A blocked read must leave dout alone as well.
        step(1'b0, 1'b1, 1'b0, 10'd10, 16'h0000);
        idle();
        total++;
        if (dout !== 16'h0001) begin
            bad++;
            $display("FAIL blk_hold got=%h exp=0001", dout);
        end
        step(1'b0, 1'b1, 1'b1, 10'd3, 16'h0000);
        flush();
    endtask

    task automatic test_read_first();
        dut.RAM[5]   = 16'h1234;
        model_mem[5] = 16'h1234;
        step(1'b1, 1'b1, 1'b1, 10'd5, 16'h5678);
        step(1'b0, 1'b1, 1'b1, 10'd5, 16'h0000);
        flush();
    endtask

    task automatic test_dout_en();
        step(1'b0, 1'b1, 1'b1, 10'd3, 16'h0000);
        flush();
        dout_en = 1'b0;
        step(1'b0, 1'b1, 1'b1, 10'd10, 16'h0000);
        idle();
        idle();
        total++;
        if (dout !== 16'hA5A5) begin
            bad++;
            $display("FAIL dout_en_hold got=%h exp=a5a5", dout);
        end
        dout_en = 1'b1;
        idle();
        total++;
        if (dout !== 16'h0001 || parity_out !== 1'b1) begin
            bad++;
            $display("FAIL dout_en_release got=%h/%b exp=0001/1", dout, parity_out);
        end
    endtask

    task automatic test_async_reset();
        // Launch a read, then reset mid-cycle while it is in flight.
        rd_en      = 1'b1;
        blk_select = 1'b1;
        addr       = 10'd3;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        total++;
        if (dout !== 16'h0000 || parity_out !== 1'b0) begin
            bad++;
            $display("FAIL async_reset got=%h/%b exp=0000/0", dout, parity_out);
        end
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL async_reset_hold got=%h exp=0000", dout);
        end
        @(negedge clk);
        rst = 1'b0;
        idle();
        total++;
        if (dout !== 16'h0000) begin
            bad++;
            $display("FAIL inflight_discard got=%h exp=0000", dout);
        end
        // Contents survive reset, including preloaded words.
        step(1'b0, 1'b1, 1'b1, 10'd3, 16'h0000);
        step(1'b0, 1'b1, 1'b1, 10'd700, 16'h0000);
        flush();
    endtask

    task automatic test_random();
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        for (int i = 0; i < 200; i++) begin
            wa = AW'($urandom_range(0, DEPTH - 1));
            ra = ($urandom_range(0, 1) == 1) ? wa : AW'($urandom_range(0, DEPTH - 1));
            step(1'b1, 1'b0, 1'b1, wa, W'($urandom));
            step(1'b0, 1'b1, 1'b1, ra, 16'h0000);
            if ($urandom_range(0, 7) == 0) idle();
        end
        flush();
    endtask

    initial begin
        rst        = 1'b1;
        din        = '0;
        addr       = '0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        blk_select = 1'b0;
        addr_en    = 1'b0;
        dout_en    = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            model_mem[i] = W'($urandom);
            dut.RAM[i]   = model_mem[i];
        end

        test_reset();
        @(negedge clk);
        test_basic();
        test_parity();
        test_blk_select();
        test_read_first();
        test_dout_en();
        @(negedge clk);
        test_async_reset();
        test_random();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
